// File: rtl/counter_ctrl_if.sv
// Pin-side and counter-side signals of the counter front-end controller.
// The controller uses the master view; the pins/counter side uses the slave view.
interface counter_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       cfg_we;
    logic [7:0] cfg_data;
    logic       inc;
    logic       up_down_sel;
    logic       carry_en;
    logic       max_en;
    logic [3:0] max_val;
    logic [1:0] state;
    logic       cfg_pending;

    modport master (
        input  btn_up, btn_down, cfg_we, cfg_data,
        output inc, up_down_sel, carry_en, max_en, max_val, state, cfg_pending
    );

    modport slave (
        output btn_up, btn_down, cfg_we, cfg_data,
        input  inc, up_down_sel, carry_en, max_en, max_val, state, cfg_pending
    );
endinterface

// File: rtl/counter_ctrl.sv
// Button front-end for the up/down digit counter: synchronise, debounce, single-pulse
// with hold-to-repeat, and idle-only application of the counter mode configuration.
module counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic          clk,
    input  logic          reset,
    counter_ctrl_if.master bus
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W = $clog2(T_MAX + 1);
    // Configuration layout: [5:2] max_val, [1] max_en, [0] carry_en
    localparam logic [5:0] CFG_RESET = {4'd9, 1'b0, 1'b0};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    logic [1:0] btn_raw;     // [0] up, [1] down
    logic [1:0] deb_level;

    assign btn_raw = {bus.btn_down, bus.btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            deb_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_reg <= ~deb_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign deb_level[gi] = deb_reg;
        end
    endgenerate

    state_t             state_reg, state_next;
    logic               inc_reg, inc_next;
    logic               sel_reg, sel_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [5:0]         cfg_reg, cfg_next;
    logic               pend_reg, pend_next;
    logic [5:0]         pend_data_reg, pend_data_next;

    logic               held;
    logic               opposite;
    logic               enter_idle;
    logic [5:0]         cfg_wdata;
    logic               cfg_unused;

    // Latched direction decides which button is "ours" during a sequence
    assign held       = sel_reg ? deb_level[1] : deb_level[0];
    assign opposite   = sel_reg ? deb_level[0] : deb_level[1];
    assign enter_idle = (state_reg != IDLE) && (state_next == IDLE);
    assign cfg_wdata  = {bus.cfg_data[7:4], bus.cfg_data[1], bus.cfg_data[0]};
    assign cfg_unused = ^bus.cfg_data[3:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            inc_reg       <= 1'b0;
            sel_reg       <= 1'b0;
            timer_reg     <= '0;
            cfg_reg       <= CFG_RESET;
            pend_reg      <= 1'b0;
            pend_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            inc_reg       <= inc_next;
            sel_reg       <= sel_next;
            timer_reg     <= timer_next;
            cfg_reg       <= cfg_next;
            pend_reg      <= pend_next;
            pend_data_reg <= pend_data_next;
        end
    end

    // Release is tested before the opposite button so it wins when both happen together
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (deb_level[0] && deb_level[1])      state_next = LOCK;
                else if (deb_level[0] || deb_level[1]) state_next = HOLD;
            end
            HOLD: begin
                if (!held)                                          state_next = IDLE;
                else if (opposite)                                  state_next = LOCK;
                else if (timer_reg == TMR_W'(REPEAT_DELAY - 1))     state_next = REPEAT;
            end
            REPEAT: begin
                if (!held)         state_next = IDLE;
                else if (opposite) state_next = LOCK;
            end
            LOCK: begin
                if (!deb_level[0] && !deb_level[1]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        inc_next       = 1'b0;
        sel_next       = sel_reg;
        timer_next     = '0;
        cfg_next       = cfg_reg;
        pend_next      = pend_reg;
        pend_data_next = pend_data_reg;

        case (state_reg)
            IDLE: begin
                if (state_next == HOLD) begin
                    inc_next = 1'b1;
                    sel_next = deb_level[1];
                end
            end
            HOLD: begin
                if (state_next == HOLD)        timer_next = timer_reg + 1'b1;
                else if (state_next == REPEAT) inc_next   = 1'b1;
            end
            REPEAT: begin
                if (state_next == REPEAT) begin
                    if (timer_reg == TMR_W'(REPEAT_PERIOD - 1)) inc_next   = 1'b1;
                    else                                        timer_next = timer_reg + 1'b1;
                end
            end
            default: ;
        endcase

        // A write landing on the IDLE entry edge supersedes any pending data
        if (bus.cfg_we && (((state_reg == IDLE) && (state_next != HOLD)) || enter_idle)) begin
            cfg_next  = cfg_wdata;
            pend_next = 1'b0;
        end else if (bus.cfg_we) begin
            pend_data_next = cfg_wdata;
            pend_next      = 1'b1;
        end else if (enter_idle && pend_reg) begin
            cfg_next  = pend_data_reg;
            pend_next = 1'b0;
        end
    end

    assign bus.inc         = inc_reg;
    assign bus.up_down_sel = sel_reg;
    assign bus.state       = state_reg;
    assign bus.carry_en    = cfg_reg[0];
    assign bus.max_en      = cfg_reg[1];
    assign bus.max_val     = cfg_reg[5:2];
    assign bus.cfg_pending = pend_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random button/config
// traffic, compared every cycle against an event-level model of the controller.
module tb_counter_ctrl;

    localparam int D  = 4;
    localparam int RD = 16;
    localparam int RP = 4;
    localparam int LAT = 3 + D;   // sample index of the first pulse after a press
    localparam logic [10:0] RESET_VEC = {1'b0, 1'b0, 2'd0, 4'd9, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    counter_ctrl_if bus();

    counter_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: raw history, debounced levels, sequence start time, config shadow
    int       k;
    bit       raw_u [0:8191];
    bit       raw_d [0:8191];
    bit       m_du, m_dd, m_sel, m_pend, e_inc;
    int       m_st, m_start;
    bit [5:0] m_cfg, m_pdata;

    function automatic bit raw_at(input int b, input int idx);
        if (idx < 1) return 1'b0;
        return (b == 1) ? raw_d[idx] : raw_u[idx];
    endfunction

    task automatic model_reset();
        k = 0; m_du = 0; m_dd = 0; m_sel = 0; m_pend = 0; e_inc = 0;
        m_st = 0; m_start = 0; m_cfg = 6'b100100; m_pdata = 6'd0;
    endtask

    task automatic model_edge(input bit up, input bit dn, input bit we, input bit [7:0] d);
        int nst;
        bit hld, opp, enter, cur, flip;
        bit [5:0] wv;
        k++;
        raw_u[k] = up;
        raw_d[k] = dn;
        nst = m_st;
        e_inc = 0;
        hld = m_sel ? m_dd : m_du;
        opp = m_sel ? m_du : m_dd;
        case (m_st)
            0: if (m_du && m_dd) nst = 3;
               else if (m_du || m_dd) begin
                   nst = 1; e_inc = 1; m_sel = m_dd; m_start = k;
               end
            1, 2: if (!hld) nst = 0;
                  else if (opp) nst = 3;
                  else if (m_st == 1 && k - m_start == RD) begin nst = 2; e_inc = 1; end
                  else if (m_st == 2 && (k - m_start - RD) % RP == 0) e_inc = 1;
            default: if (!m_du && !m_dd) nst = 0;
        endcase
        wv = {d[7:4], d[1], d[0]};
        enter = (m_st != 0) && (nst == 0);
        if (we && ((m_st == 0 && nst != 1) || enter)) begin m_cfg = wv; m_pend = 0; end
        else if (we) begin m_pdata = wv; m_pend = 1; end
        else if (enter && m_pend) begin m_cfg = m_pdata; m_pend = 0; end
        m_st = nst;
        // A level flips once the last D samples seen by the debouncer all disagree with it
        for (int b = 0; b < 2; b++) begin
            cur = (b == 1) ? m_dd : m_du;
            flip = 1;
            for (int j = k - D + 1; j <= k; j++)
                if (raw_at(b, j - 2) == cur) flip = 0;
            if (flip) begin
                if (b == 1) m_dd = ~m_dd; else m_du = ~m_du;
            end
        end
    endtask

    function automatic logic [10:0] obs_vec();
        return {bus.inc, bus.up_down_sel, bus.state, bus.max_val, bus.max_en,
                bus.carry_en, bus.cfg_pending};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {e_inc, m_sel, m_st[1:0], m_cfg[5:2], m_cfg[1], m_cfg[0], m_pend};
    endfunction

    task automatic drive(input bit up, input bit dn, input bit we, input bit [7:0] d);
        bus.btn_up = up; bus.btn_down = dn; bus.cfg_we = we; bus.cfg_data = d;
        @(posedge clk);
        model_edge(up, dn, we, d);
        #1;
        if (we) $display("[%0t] cfg write 0x%02h state=%0d", $time, d, bus.state);
        if (bus.inc === 1'b1) $display("[%0t] inc dir=%0d", $time, bus.up_down_sel);
    endtask

    task automatic test_reset();
        bus.btn_up = 0; bus.btn_down = 0; bus.cfg_we = 0; bus.cfg_data = 8'h00;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), RESET_VEC);
        end
        reset = 0;
        model_reset();
    endtask

    task automatic test_single_tap();
        int pulses = 0, first = -1;
        bit saw_hold = 0;
        for (int i = 1; i <= 22; i++) begin
            drive(i <= 10, 0, 0, 8'h00);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_tap cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (bus.inc === 1'b1) begin pulses++; if (first < 0) first = i; end
            if (bus.state === 2'd1) saw_hold = 1;
        end
        n_checks++;
        if (pulses != 1 || first != LAT) begin
            n_fail++;
            $display("FAIL single_tap_latency: got %0d pulses first at %0d, expected 1 at %0d", pulses, first, LAT);
        end
        n_checks++;
        if (!saw_hold || bus.state !== 2'd0 || bus.up_down_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL single_tap_state: saw_hold=%0d state=%0d sel=%0d, expected 1 0 0", saw_hold, bus.state, bus.up_down_sel);
        end
    endtask

    task automatic test_auto_repeat();
        int q[$];
        bit sel_ok = 1;
        for (int i = 1; i <= 55; i++) begin
            drive(0, i <= 40, 0, 8'h00);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL auto_repeat cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (bus.inc === 1'b1) begin q.push_back(i); if (bus.up_down_sel !== 1'b1) sel_ok = 0; end
        end
        n_checks++;
        if (q.size() != 7 || q[0] != LAT || q[1] - q[0] != RD || q[2] - q[1] != RP || !sel_ok) begin
            n_fail++;
            $display("FAIL auto_repeat_spacing: got %0d pulses first %0d, expected 7 first %0d gaps %0d/%0d", q.size(), (q.size() > 0) ? q[0] : -1, LAT, RD, RP);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            drive(i <= 2, 0, 0, 8'h00);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL glitch cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (bus.inc === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL glitch_pulses: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_conflict();
        int pulses = 0;
        bit saw_lock = 0;
        for (int i = 1; i <= 45; i++) begin
            drive(i <= 12, i <= 28, 0, 8'h00);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL conflict cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (bus.inc === 1'b1) pulses++;
            if (bus.state === 2'd3) saw_lock = 1;
        end
        n_checks++;
        if (pulses != 0 || !saw_lock || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL conflict_lock: pulses=%0d saw_lock=%0d state=%0d, expected 0 1 0", pulses, saw_lock, bus.state);
        end
    endtask

    task automatic test_deferred_cfg();
        for (int i = 1; i <= 42; i++) begin
            drive(i <= 30, 0, i == 26, 8'h53);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL deferred_cfg cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 26) begin
                n_checks++;
                if (bus.cfg_pending !== 1'b1 || bus.max_val !== 4'd9 || bus.carry_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL deferred_pending: pend=%0d max_val=%0d carry=%0d, expected 1 9 0", bus.cfg_pending, bus.max_val, bus.carry_en);
                end
            end
        end
        n_checks++;
        if ({bus.carry_en, bus.max_en, bus.max_val, bus.cfg_pending} !== {1'b1, 1'b1, 4'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL deferred_apply: got %b %b %0d pend %b, expected 1 1 5 pend 0", bus.carry_en, bus.max_en, bus.max_val, bus.cfg_pending);
        end
    endtask

    task automatic test_overwrite();
        for (int i = 1; i <= 42; i++) begin
            drive(0, i <= 30, (i == 25) || (i == 27), (i == 25) ? 8'h71 : 8'h12);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL overwrite cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({bus.carry_en, bus.max_en, bus.max_val} !== {1'b0, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL overwrite_apply: got %b %b %0d, expected 0 1 1", bus.carry_en, bus.max_en, bus.max_val);
        end
    endtask

    task automatic test_cfg_idle();
        drive(0, 0, 1, 8'hA3);
        n_checks++;
        if ({bus.carry_en, bus.max_en, bus.max_val, bus.cfg_pending} !== {1'b1, 1'b1, 4'd10, 1'b0}) begin
            n_fail++;
            $display("FAIL cfg_idle: got %b %b %0d pend %b, expected 1 1 10 pend 0", bus.carry_en, bus.max_en, bus.max_val, bus.cfg_pending);
        end
    endtask

    task automatic test_random();
        int left = 0;
        bit up = 0, dn = 0;
        for (int i = 1; i <= 900; i++) begin
            if (left == 0) begin
                up = $urandom_range(0, 1);
                dn = $urandom_range(0, 2) == 0;
                left = $urandom_range(1, 40);
            end
            left--;
            drive(up, dn, $urandom_range(0, 9) == 0, 8'($urandom));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 1; i <= 12; i++) drive(0, 0, 0, 8'h00);
    endtask

    task automatic test_reset_mid();
        int first = -1;
        for (int i = 1; i <= 28; i++) begin
            drive(1, 0, i == 27, 8'hF0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        reset = 1;
        #2;
        n_checks++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h expected %h", obs_vec(), RESET_VEC);
        end
        reset = 0;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            drive(1, 0, 0, 8'h00);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_post cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (bus.inc === 1'b1 && first < 0) first = i;
        end
        n_checks++;
        if (first != LAT) begin
            n_fail++;
            $display("FAIL reset_mid_latency: got first pulse at %0d expected %0d", first, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_auto_repeat();
        test_glitch();
        test_conflict();
        test_deferred_cfg();
        test_overwrite();
        test_cfg_idle();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
